// File: rtl/decode_issue.sv
// decode_issue: single-entry decode/issue stage with a register scoreboard.
//
// Holds at most one fetched instruction, decodes its fields and class flags,
// and issues it to execute only when none of its source/destination
// registers are pending writeback. Issued instructions that write rd mark
// that register busy until the matching writeback arrives.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   in_valid/in_ready     fetch handshake, in_instr carries the instruction
//                         {opcode[31:27], rd[26:22], rs[21:17], rt[16:12], L[11:0]}
//   out_valid/out_ready   issue handshake to execute
//   opcode, readAddress1 (rs), readAddress2 (rt), writeAddress (rd), L
//                         fields of the held instruction
//   lPassed               held opcode takes L as operand 2 (rt unused)
//   rd_write              held instruction writes rd
//   illegal               held opcode is above 5'h1D
//   flush                 drop the held, not-yet-issued instruction
//   wb_valid/wb_addr      register writeback completing this cycle
module decode_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  opcode,
  output logic [4:0]  readAddress1,
  output logic [4:0]  readAddress2,
  output logic [4:0]  writeAddress,
  output logic        lPassed,
  output logic [11:0] L,
  output logic        rd_write,
  output logic        illegal,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr
);

  logic        held_q, held_d;
  logic [31:0] instr_q, instr_d;
  logic        lpassed_q, lpassed_d;
  logic        rd_write_q, rd_write_d;
  logic        illegal_q, illegal_d;
  logic [31:0] busy_q, busy_d;

  logic [31:0] busy_eff;
  logic        hazard;
  logic        fire;
  logic        accept;
  logic [4:0]  in_op;

  // Class flags are decoded from the incoming opcode and registered with the
  // instruction, so the outputs come straight from flops.
  always_comb begin
    in_op      = in_instr[31:27];
    illegal_d  = (in_op > 5'h1D);
    lpassed_d  = 1'b0;
    rd_write_d = 1'b0;
    case (in_op)
      5'h05, 5'h07, 5'h0A, 5'h12, 5'h19, 5'h1B: lpassed_d = 1'b1;
      default:                                  lpassed_d = 1'b0;
    endcase
    case (in_op) inside
      [5'h00:5'h07], [5'h10:5'h12], [5'h14:5'h1D]: rd_write_d = 1'b1;
      default:                                     rd_write_d = 1'b0;
    endcase
  end

  // Field views of the held instruction.
  always_comb begin
    opcode       = instr_q[31:27];
    writeAddress = instr_q[26:22];
    readAddress1 = instr_q[21:17];
    readAddress2 = instr_q[16:12];
    L            = instr_q[11:0];
    lPassed      = lpassed_q;
    rd_write     = rd_write_q;
    illegal      = illegal_q;
  end

  // The same-cycle writeback is folded in before the hazard check so a
  // completing write releases a stalled consumer without an extra cycle.
  always_comb begin
    busy_eff = busy_q;
    if (wb_valid) begin
      busy_eff[wb_addr] = 1'b0;
    end
    hazard    = busy_eff[readAddress1] | busy_eff[writeAddress] |
                (!lpassed_q & busy_eff[readAddress2]);
    out_valid = held_q & !hazard & !flush;
    fire      = out_valid & out_ready;
    in_ready  = !held_q | fire | flush;
    accept    = in_valid & in_ready;
  end

  always_comb begin
    held_d  = held_q;
    instr_d = instr_q;
    if (accept) begin
      held_d  = 1'b1;
      instr_d = in_instr;
    end else if (fire || flush) begin
      held_d = 1'b0;
    end

    // Set after clear: an issue to the register being written back wins.
    busy_d = busy_eff;
    if (fire && rd_write_q) begin
      busy_d[writeAddress] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q     <= 1'b0;
      instr_q    <= '0;
      lpassed_q  <= 1'b0;
      rd_write_q <= 1'b0;
      illegal_q  <= 1'b0;
      busy_q     <= '0;
    end else begin
      held_q <= held_d;
      busy_q <= busy_d;
      if (accept) begin
        instr_q    <= instr_d;
        lpassed_q  <= lpassed_d;
        rd_write_q <= rd_write_d;
        illegal_q  <= illegal_d;
      end
    end
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 The block SHALL have no parameters; the instruction width is fixed at 32 bits and the register count at 32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-004 in_valid  input  1  fetch presents an instruction.
REQ-005 in_instr  input  32  fields: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], L[11:0].
REQ-006 in_ready  output  1  block accepts in_instr this cycle.
REQ-007 out_valid  output  1  decoded instruction is issuable.
REQ-008 out_ready  input  1  execute stage consumes the instruction.
REQ-009 opcode  output  5  held opcode.
REQ-010 readAddress1, readAddress2, writeAddress  output  5 each  rs, rt, rd of the held instruction.
REQ-011 lPassed  output  1  the held opcode uses L as operand 2.
REQ-012 L  output  12  held literal.
REQ-013 rd_write  output  1  the held instruction writes rd.
REQ-014 illegal  output  1  held opcode > 5'h1D.
REQ-015 flush  input  1  discard the held, not-yet-issued instruction.
REQ-016 wb_valid  input  1  register-file write completing this cycle.
REQ-017 wb_addr  input  5  register being written back.

Function
REQ-018 The block SHALL hold at most one instruction in a single decode register with a held flag.
- Transfers: accept = in_valid & in_ready; fire = out_valid & out_ready.
REQ-019 in_ready SHALL equal !held | fire | flush.
REQ-020 On accept, the block SHALL load the instruction and set held, giving one cycle of latency from in_instr to the outputs.
- With no accept: fire or flush clears held.
- A simultaneous accept reloads the register.
REQ-021 lPassed SHALL be 1 exactly for opcodes 5'h05, 5'h07, 5'h0A, 5'h12, 5'h19 and 5'h1B.
REQ-022 rd_write SHALL be 1 exactly for opcodes 5'h00-5'h07, 5'h10-5'h12 and 5'h14-5'h1D.
- rd_write SHALL be 0 for illegal opcodes.
REQ-023 The block SHALL keep a 32-bit scoreboard busy[31:0].
- Update order each edge: clear busy[wb_addr] on wb_valid, then set busy[writeAddress] on fire & rd_write.
- When set and clear target the same register, set wins.
REQ-024 hazard SHALL be busy_eff[rs] | busy_eff[rd] | (!lPassed & busy_eff[rt]).
- busy_eff = busy with the current-cycle wb_valid clear already applied, so a same-cycle writeback releases the stall.
REQ-025 out_valid SHALL equal held & !hazard & !flush.
REQ-026 Output fields SHALL stay stable while held & !fire, including while stalled.
REQ-027 An illegal instruction SHALL issue normally with illegal=1 and SHALL NOT set any busy bit.
REQ-028 flush SHALL NOT alter the scoreboard, because busy bits belong only to instructions that have already issued.
REQ-029 When a stall lasts indefinitely, the block SHALL keep in_ready=0 and produce no output change.

Reset
REQ-030 While reset is high, the block SHALL hold held=0, busy=0, out_valid=0, in_ready=1, and all field outputs at 0.
REQ-031 Reset asserted mid-stall SHALL discard the held instruction and all busy bits; the first accept after deassertion SHALL decode normally.

Verification
REQ-032 add r3,r1,r2 (5'h18) accepted with out_ready=1 -> next cycle out_valid=1, writeAddress=3, rd_write=1, lPassed=0; after fire, busy[3]=1.
REQ-033 add r3,r1,r2 issued, then sub r4,r3,r5 accepted -> out_valid=0 and in_ready=0 until wb_valid with wb_addr=3; out_valid=1 in that same cycle.
REQ-034 addi r6,L=12'hFFF with busy[rt-field]=1 -> out_valid=1, lPassed=1, L=12'hFFF, because rt is ignored.
REQ-035 flush asserted while a stalled instruction is held -> out_valid=0 the same cycle, held=0 next cycle, busy unchanged.
REQ-036 wb_valid with wb_addr=7 coinciding with fire of mul r7 -> busy[7]=1 afterwards.
REQ-037 reset pulsed while busy=32'hFFFF_FFFF and held=1 -> busy=0, out_valid=0, in_ready=1 immediately.
